// File: rtl/dmem_responder.sv
// Single-port word memory slave with a fixed, parameterised number of wait states.
// Each request gets one ack pulse; requests outside the mapped window get err and no side effect.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  byte_en,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        ack,
    output logic        err
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dout_q, dout_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          acc_we;
    logic [3:0]    acc_be;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_din;
    logic [31:0]   acc_off;
    logic          acc_in_range;
    logic [AW-1:0] acc_idx;
    logic          go_resp;
    logic          mem_wr;

    // With no wait states the access completes on the capture edge, so it must use the live inputs.
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            acc_we   = we;
            acc_be   = byte_en;
            acc_addr = addr;
            acc_din  = din;
        end else begin
            acc_we   = we_q;
            acc_be   = be_q;
            acc_addr = addr_q;
            acc_din  = din_q;
        end
        acc_off      = acc_addr - BASE_ADDR;
        acc_in_range = (acc_addr >= BASE_ADDR) && (acc_off < SPAN);
        acc_idx      = acc_off[AW+1:2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        din_d   = din_q;
        go_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel) begin
                    we_d   = we;
                    be_d   = byte_en;
                    addr_d = addr;
                    din_d  = din;
                    cnt_d  = CNT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!sel) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response flops are loaded on the edge entering RESP so they are valid throughout the ack cycle.
    always_comb begin
        ack_d  = go_resp;
        err_d  = go_resp && !acc_in_range;
        dout_d = dout_q;
        mem_wr = go_resp && acc_we && acc_in_range;
        if (go_resp) begin
            if (!acc_in_range) begin
                dout_d = 32'h0;
            end else if (!acc_we) begin
                dout_d = mem_q[acc_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= 32'h0;
            din_q   <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem_q[acc_idx][8*b +: 8] <= acc_din[8*b +: 8];
                end
            end
        end
    end

    assign ack  = ack_q;
    assign err  = err_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder, three instances with different wait/depth/base.
// Expected responses come from a transaction-level memory model kept here.
module tb_dmem_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        sel  [3];
    logic        we   [3];
    logic [3:0]  be   [3];
    logic [31:0] addr [3];
    logic [31:0] din  [3];
    logic [31:0] dout [3];
    logic        ack  [3];
    logic        err  [3];

    int unsigned wcyc  [3] = '{1, 3, 0};
    int unsigned depth [3] = '{1024, 16, 1024};
    logic [31:0] base  [3] = '{32'h0, 32'h1000, 32'h0};

    logic [31:0] mdl      [3][1024];
    logic [31:0] exp_dout [3];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n), .sel(sel[0]), .we(we[0]), .byte_en(be[0]), .addr(addr[0]),
        .din(din[0]), .dout(dout[0]), .ack(ack[0]), .err(err[0]));

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(3), .BASE_ADDR(32'h1000)) u_dut_w3 (
        .clk(clk), .rst_n(rst_n), .sel(sel[1]), .we(we[1]), .byte_en(be[1]), .addr(addr[1]),
        .din(din[1]), .dout(dout[1]), .ack(ack[1]), .err(err[1]));

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n), .sel(sel[2]), .we(we[2]), .byte_en(be[2]), .addr(addr[2]),
        .din(din[2]), .dout(dout[2]), .ack(ack[2]), .err(err[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic bit in_rng(input int d, input logic [31:0] a);
        return (a >= base[d]) && (((a - base[d]) >> 2) < depth[d]);
    endfunction

    function automatic logic [31:0] pool_addr(input int d, input int k);
        int unsigned w;
        w = (k < 6) ? k : depth[d] - 8 + k;
        return base[d] + 4 * w;
    endfunction

    // One complete request; inputs are scrambled while busy to show the captured fields are held.
    task automatic txn(input int d, input bit w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] data);
        int n;
        bit inr;
        int idx;
        inr = in_rng(d, a);
        idx = inr ? int'((a - base[d]) >> 2) : 0;
        @(negedge clk);
        sel[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; din[d] = data;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1 && wcyc[d] > 0) begin
                we[d] = 1'($urandom); be[d] = 4'($urandom); addr[d] = $urandom; din[d] = $urandom;
            end
        end while (!ack[d] && n < 40);
        check($sformatf("latency[%0d]", d), n, wcyc[d] + 1);
        check($sformatf("err[%0d] @%h", d, a), err[d], {31'b0, !inr});
        if (!inr) exp_dout[d] = 32'h0;
        else if (!w) exp_dout[d] = mdl[d][idx];
        check($sformatf("dout[%0d] @%h", d, a), dout[d], exp_dout[d]);
        if (w && inr) begin
            for (int k = 0; k < 4; k++) if (b[k]) mdl[d][idx][8*k +: 8] = data[8*k +: 8];
        end
        sel[d] = 1'b0;
        @(posedge clk); #1;
        check($sformatf("ack_pulse[%0d]", d), ack[d], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, data, last_wr;
        bit seen;
        for (int d = 0; d < 3; d++) begin
            sel[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; addr[d] = 32'h0; din[d] = 32'h0;
            exp_dout[d] = 32'h0;
        end

        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_ack[%0d]", d), ack[d], 1'b0);
            check($sformatf("rst_err[%0d]", d), err[d], 1'b0);
            check($sformatf("rst_dout[%0d]", d), dout[d], 32'h0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Basic write/read, byte mask, zero mask, out-of-range on the one-wait-state instance.
        txn(0, 1, 4'hF, 32'h10, 32'hDEADBEEF);
        txn(0, 0, 4'hF, 32'h10, 32'h0);
        check("deadbeef", dout[0], 32'hDEADBEEF);
        txn(0, 1, 4'hF, 32'h20, 32'h11223344);
        txn(0, 1, 4'b0101, 32'h20, 32'hAABBCCDD);
        txn(0, 0, 4'hF, 32'h20, 32'h0);
        check("bytemask", dout[0], 32'h11BB33DD);
        txn(0, 1, 4'hF, 32'h0, 32'h0BADF00D);
        txn(0, 1, 4'h0, 32'h10, 32'hFFFFFFFF);
        txn(0, 0, 4'hF, 32'h10, 32'h0);
        txn(0, 0, 4'hF, 32'h1000, 32'h0);
        check("oor_err", err[0], 1'b0);
        txn(0, 1, 4'hF, 32'h1000, 32'h77777777);
        txn(0, 0, 4'hF, 32'h0, 32'h0);
        txn(0, 0, 4'hF, 32'h10, 32'h0);

        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 8; k++) txn(d, 1, 4'hF, pool_addr(d, k), $urandom);

        // Abort: sel withdrawn one cycle into the wait period.
        a = pool_addr(1, 2);
        @(negedge clk);
        sel[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = a; din[1] = 32'h55AA55AA;
        @(posedge clk);
        @(negedge clk) sel[1] = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | ack[1];
        end
        check("abort_ack", seen, 1'b0);
        txn(1, 0, 4'hF, a, 32'h0);

        // Reset asserted while a write waits.
        a = pool_addr(1, 3);
        txn(1, 0, 4'hF, a, 32'h0);
        @(negedge clk);
        sel[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = a; din[1] = ~mdl[1][3];
        @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midrst_ack", ack[1], 1'b0);
        check("midrst_err", err[1], 1'b0);
        check("midrst_dout", dout[1], 32'h0);
        sel[1] = 1'b0;
        for (int d = 0; d < 3; d++) exp_dout[d] = 32'h0;
        @(negedge clk) rst_n = 1'b1;
        txn(1, 0, 4'hF, a, 32'h0);

        // Zero wait states, sel held high, alternating write/read of word 1.
        last_wr = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sel[2] = 1'b1; addr[2] = 32'h4; be[2] = 4'hF; we[2] = (i % 2 == 0);
            data = $urandom;
            din[2] = data;
            @(posedge clk); #1;
            check($sformatf("b2b_ack%0d", i), ack[2], 1'b1);
            if (i % 2 == 0) begin
                last_wr = data;
                mdl[2][1] = data;
            end else begin
                check($sformatf("b2b_dout%0d", i), dout[2], last_wr);
                exp_dout[2] = last_wr;
            end
            @(posedge clk); #1;
            check($sformatf("b2b_gap%0d", i), ack[2], 1'b0);
        end
        sel[2] = 1'b0;

        // Random traffic over a pool of initialised words plus out-of-range addresses.
        for (int d = 0; d < 3; d++) begin
            for (int t = 0; t < 30; t++) begin
                case ($urandom_range(0, 9))
                    0:       a = base[d] + 4 * depth[d];
                    1:       a = (d == 1) ? base[d] - 4 : 32'hFFFF_FFFC;
                    default: a = pool_addr(d, int'($urandom_range(0, 7)));
                endcase
                a = a | 32'($urandom_range(0, 3));
                txn(d, 1'($urandom), 4'($urandom), a, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
